// File: rtl/alu_pkg.sv
// Shared encodings for the ALU and its front-end arbiter: FSM state codes and
// ALUOp values.
package alu_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SRL = 3'd4;
  localparam logic [2:0] ALU_SRA = 3'd5;

endpackage

// File: rtl/alu.sv
// Combinational ALU: C = A <ALUOp> B. Shifts use the low log2(WIDTH) bits of B;
// unused opcodes return zero.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [OPW-1:0]   ALUOp,
  output logic [WIDTH-1:0] C
);

  localparam int SHW = $clog2(WIDTH);

  logic [2:0]     op;
  logic [SHW-1:0] shamt;

  assign op    = ALUOp[2:0];
  assign shamt = B[SHW-1:0];

  always_comb begin
    C = '0;
    case (op)
      ALU_ADD: C = A + B;
      ALU_SUB: C = A - B;
      ALU_AND: C = A & B;
      ALU_OR:  C = A | B;
      ALU_SRL: C = A >> shamt;
      ALU_SRA: C = WIDTH'($signed(A) >>> shamt);
      default: C = '0;
    endcase
  end

endmodule

// File: rtl/rr_pick2.sv
// Two-way round-robin picker. 'last' is the index of the previous winner; on a
// tie the other requester is chosen. Output is one-hot (or zero).
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one ALU between two valid/ready requesters.
// Define ALU_ARB_B2B_EN to allow a new grant in the cycle a response completes.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Requesters hold their request stable until ready; the arbiter holds
  // rsp data stable while rsp_valid is high and rsp_ready is low.

  state_t           state_q, state_d;
  logic             last_q;
  logic             owner_q;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] alu_c;

  logic [1:0] valid_vec, grant, ready_vec;
  logic       grant_en, accept, acc_owner, rsp_fire;

  assign valid_vec = {req1_valid, req0_valid};

  rr_pick2 u_pick (
    .valid (valid_vec),
    .last  (last_q),
    .grant (grant)
  );

  alu #(.WIDTH(WIDTH), .OPW(OPW)) u_alu (
    .A     (a_q),
    .B     (b_q),
    .ALUOp (op_q),
    .C     (alu_c)
  );

  assign rsp_fire = (state_q == ST_RESP) && (owner_q ? rsp1_ready : rsp0_ready);

  // State register and datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q <= acc_owner;
        last_q  <= acc_owner;
        a_q     <= acc_owner ? req1_a  : req0_a;
        b_q     <= acc_owner ? req1_b  : req0_b;
        op_q    <= acc_owner ? req1_op : req0_op;
      end
      if (state_q == ST_EXEC) result_q <= alu_c;
    end
  end

  // Next-state logic. accept can only be set in RESP when back-to-back is built in.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_fire) state_d = accept ? ST_EXEC : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    grant_en = (state_q == ST_IDLE);
`ifdef ALU_ARB_B2B_EN
    if (rsp_fire) grant_en = 1'b1;
`endif
    ready_vec  = grant & {2{grant_en}};
    accept     = |(ready_vec & valid_vec);
    acc_owner  = ready_vec[1];
    req0_ready = ready_vec[0];
    req1_ready = ready_vec[1];
    rsp0_valid = (state_q == ST_RESP) && !owner_q;
    rsp1_valid = (state_q == ST_RESP) && owner_q;
    rsp0_data  = rsp0_valid ? result_q : '0;
    rsp1_data  = rsp1_valid ? result_q : '0;
    busy       = (state_q != ST_IDLE);
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter against a transaction-level
// model: one op in flight, response one cycle after the execute cycle.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int W = 32;
  localparam int OPW = 3;
`ifdef ALU_ARB_B2B_EN
  localparam int ACC_GAP = 2;
`else
  localparam int ACC_GAP = 3;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
  logic [W-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [OPW-1:0] req0_op = 0, req1_op = 0;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
  logic [W-1:0] rsp0_data, rsp1_data;
  logic [1:0] dbg_state;

  alu_arbiter #(.WIDTH(W), .OPW(OPW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_op(req0_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_op(req1_op),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Model and scoreboard
  int n_vec = 0, n_err = 0, cyc = 0;
  bit m_pend = 0, m_owner = 0, m_last = 1;
  int m_age = 0;
  logic [W-1:0] exp_q[$];
  int acc_own[$], acc_cyc[$], fire_cyc[$];
  logic [W-1:0] got0[$], got1[$];
  bit acc0 = 0, acc1 = 0, refill0 = 0, refill1 = 0;

  function automatic logic [W-1:0] alu_ref(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] op);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SRL: return a >> b[4:0];
      ALU_SRA: return W'($signed(a) >>> b[4:0]);
      default: return '0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Driver tasks
  task automatic set_req(input int n, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    if (n == 0) begin req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; end
    else        begin req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; end
  endtask

  task automatic new_op(input int n);
    set_req(n, $urandom(), $urandom(), 3'($urandom_range(0, 5)));
  endtask

  // One clock: check outputs at negedge against the model, advance the model,
  // then step past the rising edge and refill/drop accepted requests.
  task automatic tick();
    logic ev0, ev1, fire, free, er0, er1;
    logic [W-1:0] ed;
    @(negedge clk);
    ev0 = m_pend && m_age >= 1 && !m_owner;
    ev1 = m_pend && m_age >= 1 && m_owner;
    ed = (exp_q.size() > 0) ? exp_q[0] : '0;
    fire = (ev0 && rsp0_ready) || (ev1 && rsp1_ready);
    free = !m_pend;
`ifdef ALU_ARB_B2B_EN
    if (fire) free = 1'b1;
`endif
    er0 = free && req0_valid && (!req1_valid || m_last);
    er1 = free && req1_valid && (!req0_valid || !m_last);
    check("req0_ready", req0_ready, er0);
    check("req1_ready", req1_ready, er1);
    check("ready_excl", req0_ready & req1_ready, 0);
    check("rsp0_valid", rsp0_valid, ev0);
    check("rsp1_valid", rsp1_valid, ev1);
    if (ev0) check("rsp0_data", rsp0_data, ed);
    if (ev1) check("rsp1_data", rsp1_data, ed);
    check("busy", busy, m_pend);
    if (fire) begin
      if (ev0) got0.push_back(rsp0_data); else got1.push_back(rsp1_data);
      fire_cyc.push_back(cyc);
      void'(exp_q.pop_front());
      m_pend = 0;
    end else if (m_pend) m_age++;
    acc0 = er0;
    acc1 = er1;
    if (er0 || er1) begin
      m_pend = 1; m_age = 0; m_owner = er1; m_last = er1;
      exp_q.push_back(er1 ? alu_ref(req1_a, req1_b, req1_op[2:0])
                          : alu_ref(req0_a, req0_b, req0_op[2:0]));
      acc_own.push_back(int'(er1));
      acc_cyc.push_back(cyc);
    end
    @(posedge clk); #1;
    cyc++;
    if (acc0) begin if (refill0) new_op(0); else req0_valid = 0; end
    if (acc1) begin if (refill1) new_op(1); else req1_valid = 0; end
  endtask

  task automatic drain();
    refill0 = 0; refill1 = 0;
    for (int i = 0; i < 20 && (m_pend || req0_valid || req1_valid); i++) tick();
    check("drain_idle", m_pend, 0);
  endtask

  task automatic apply_reset();
    reset = 1;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    #1;
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_rsp0_valid", rsp0_valid, 0);
    check("rst_rsp1_valid", rsp1_valid, 0);
    check("rst_rsp0_data", rsp0_data, 0);
    check("rst_rsp1_data", rsp1_data, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, ST_IDLE);
    m_pend = 0; m_last = 1; m_age = 0; exp_q.delete();
    acc0 = 0; acc1 = 0;
    @(posedge clk); @(negedge clk);
    reset = 0;
    @(posedge clk); #1;
  endtask

  int base, n0, n1;

  initial begin
    #2;
    apply_reset();
    tick();

    // Single op: 5 + 7 on requester 0
    rsp0_ready = 1; rsp1_ready = 1;
    n0 = got0.size();
    set_req(0, 5, 7, ALU_ADD);
    tick();
    check("single_accept", acc0, 1);
    for (int i = 0; i < 10 && got0.size() == n0; i++) tick();
    check("single_rsp_seen", got0.size(), n0 + 1);
    if (got0.size() > n0) begin
      check("single_data", got0[$], 12);
      check("single_latency", fire_cyc[$] - acc_cyc[$], 2);
    end
    check("single_no_rsp1", got1.size(), 0);
    drain();

    // Simultaneous requests after a tie-break reset
    apply_reset();
    rsp0_ready = 1; rsp1_ready = 1;
    n0 = got0.size(); n1 = got1.size(); base = acc_own.size();
    set_req(0, 3, 5, ALU_SUB);
    set_req(1, 32'h0000_00F0, 32'h0000_000F, ALU_OR);
    for (int i = 0; i < 20 && got1.size() == n1; i++) tick();
    check("simul_count", acc_own.size(), base + 2);
    if (acc_own.size() >= base + 2) begin
      check("simul_first", acc_own[base], 0);
      check("simul_second", acc_own[base + 1], 1);
    end
    if (got0.size() > n0) check("simul_rsp0", got0[$], 32'hFFFF_FFFE);
    else check("simul_rsp0_seen", got0.size(), n0 + 1);
    if (got1.size() > n1) check("simul_rsp1", got1[$], 32'h0000_00FF);
    else check("simul_rsp1_seen", got1.size(), n1 + 1);
    drain();

    // Fairness and accept spacing with both requesters always valid
    base = acc_own.size();
    refill0 = 1; refill1 = 1;
    new_op(0); new_op(1);
    for (int i = 0; i < 40 && acc_own.size() < base + 6; i++) tick();
    check("fair_count", acc_own.size() >= base + 6, 1);
    if (acc_own.size() >= base + 6)
      for (int k = 0; k < 6; k++) begin
        check($sformatf("fair_order%0d", k), acc_own[base + k], k % 2);
        if (k > 0) check($sformatf("acc_gap%0d", k), acc_cyc[base + k] - acc_cyc[base + k - 1], ACC_GAP);
      end
    drain();

    // Back-pressure on requester 1 while requester 0 waits
    rsp1_ready = 0; rsp0_ready = 1;
    n1 = got1.size();
    set_req(1, $urandom(), $urandom(), ALU_SRA);
    tick();
    check("bp_accept1", acc1, 1);
    set_req(0, $urandom(), $urandom(), ALU_AND);
    for (int i = 0; i < 10 && !rsp1_valid; i++) tick();
    check("bp_rsp1_valid", rsp1_valid, 1);
    for (int i = 0; i < 5; i++) tick();
    check("bp_held", got1.size(), n1);
    rsp1_ready = 1;
    for (int i = 0; i < 10 && got1.size() == n1; i++) tick();
    check("bp_released", got1.size(), n1 + 1);
    drain();

    // Reset while a response is pending
    rsp0_ready = 0;
    set_req(0, $urandom(), $urandom(), ALU_SRL);
    for (int i = 0; i < 10 && !rsp0_valid; i++) tick();
    check("rr_rsp0_pending", rsp0_valid, 1);
    #2;
    apply_reset();
    rsp0_ready = 1; rsp1_ready = 1;
    base = acc_own.size();
    new_op(0); new_op(1);
    tick();
    check("rr_tie_count", acc_own.size(), base + 1);
    if (acc_own.size() > base) check("rr_tie_winner", acc_own[base], 0);
    drain();

    // Random traffic with drops and response back-pressure
    for (int i = 0; i < 800; i++) begin
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
      if (!req0_valid) begin if ($urandom_range(0, 1) == 1) new_op(0); end
      else if ($urandom_range(0, 9) == 0) req0_valid = 0;
      if (!req1_valid) begin if ($urandom_range(0, 1) == 1) new_op(1); end
      else if ($urandom_range(0, 9) == 0) req1_valid = 0;
      tick();
    end
    rsp0_ready = 1; rsp1_ready = 1;
    drain();
    check("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
